tick_sched: RTL and testbench

TICK_SCHED -- requirements
Module: tick_sched

---
 rtl/tick_sched_pkg.sv | 19 +
 rtl/tick_sched_if.sv | 27 ++
 rtl/tick_sched_rr_arb4.sv | 23 ++
 rtl/tick_sched.sv | 121 ++++++++++++
 tb/tb_tick_sched.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/tick_sched_pkg.sv
// Shared types and constants for the tick scheduler: channel count, channel
// mode and the per-channel configuration record.
package tick_sched_pkg;

    localparam int NCH      = 4;
    localparam int PERIOD_W = 32;   // widest period any channel may be built with

    typedef enum logic {
        PERIODIC = 1'b0,
        ONESHOT  = 1'b1
    } ch_mode_e;

    typedef struct packed {
        logic [PERIOD_W-1:0] period;
        ch_mode_e            mode;
        logic                en;
    } ch_cfg_t;

endpackage

// File: rtl/tick_sched_if.sv
// Config-write and event handshakes of the tick scheduler. Both channels use
// valid/ready: a transfer happens on a rising clk edge where valid and ready are
// both high; the source holds its payload stable while valid is high and ready low.
interface tick_sched_if #(parameter int PW = 16);

    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_ch;
    logic [PW-1:0] cfg_period;
    logic          cfg_mode;
    logic          cfg_en;

    logic          evt_valid;
    logic          evt_ready;
    logic [1:0]    evt_ch;

    modport master (
        output cfg_valid, cfg_ch, cfg_period, cfg_mode, cfg_en, evt_ready,
        input  cfg_ready, evt_valid, evt_ch
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_period, cfg_mode, cfg_en, evt_ready,
        output cfg_ready, evt_valid, evt_ch
    );

endinterface

// File: rtl/tick_sched_rr_arb4.sv
// Four-way round-robin selector: the first requesting index at or after ptr wins.
module rr_arb4
    import tick_sched_pkg::*;
(
    input  logic [NCH-1:0] req,
    input  logic [1:0]     ptr,
    output logic [1:0]     gnt_id,
    output logic           any
);

    always_comb begin
        gnt_id = ptr;
        // Walk from the far end so the nearest request to ptr is the last write.
        for (int k = NCH - 1; k >= 0; k--) begin
            if (req[ptr + 2'(k)]) begin
                gnt_id = ptr + 2'(k);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/tick_sched.sv
// Four-channel tick scheduler: a prescaler produces base ticks, each channel
// counts them down and posts expiry events that are drained round-robin.
module tick_sched
    import tick_sched_pkg::*;
#(
    parameter int PRESCALE = 50000,
    parameter int PW       = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    tick_sched_if.slave    bus,
    output logic           base_tick,
    output logic [NCH-1:0] ch_tick,
    output logic [NCH-1:0] ovf,
    input  logic           ovf_clr
);

    localparam int PCW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    logic [PCW-1:0] pre_cnt;
    ch_cfg_t        cfg [NCH];
    logic [PW-1:0]  cnt [NCH];
    logic [NCH-1:0] pending;
    logic [1:0]     ptr;

    logic           cfg_acc;
    logic           hs;
    logic [NCH-1:0] active;
    logic [NCH-1:0] expire;
    logic [NCH-1:0] hs_clr;
    logic [NCH-1:0] pending_nxt;
    logic [NCH-1:0] ovf_set;
    logic [1:0]     ptr_nxt;
    logic [1:0]     gnt_id;
    logic           gnt_any;

    // base_tick is registered one count early so it mirrors pre_cnt == PRESCALE-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt   <= '0;
            base_tick <= 1'b0;
        end else begin
            pre_cnt   <= (pre_cnt == PCW'(PRESCALE - 1)) ? '0 : pre_cnt + PCW'(1);
            base_tick <= (pre_cnt == PCW'(PRESCALE - 2));
        end
    end

    // Config is refused in base-tick cycles so a write never races a decrement.
    assign bus.cfg_ready = ~base_tick;
    assign cfg_acc       = bus.cfg_valid & bus.cfg_ready;
    assign hs            = bus.evt_valid & bus.evt_ready;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            active[i] = cfg[i].en && (cfg[i].period != '0);
            expire[i] = base_tick && active[i] && (cnt[i] == PW'(1));
        end
        hs_clr      = hs ? (NCH'(1) << bus.evt_ch) : '0;
        pending_nxt = (pending & ~hs_clr) | expire;
        ovf_set     = expire & pending & ~hs_clr;
        ptr_nxt     = hs ? bus.evt_ch + 2'd1 : ptr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                cfg[i] <= '0;
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (cfg_acc && (bus.cfg_ch == 2'(i))) begin
                    cfg[i].period <= PERIOD_W'(bus.cfg_period);
                    cfg[i].mode   <= ch_mode_e'(bus.cfg_mode);
                    cfg[i].en     <= bus.cfg_en;
                    cnt[i]        <= bus.cfg_period;
                end else if (base_tick && active[i]) begin
                    if (cnt[i] > PW'(1)) begin
                        cnt[i] <= cnt[i] - PW'(1);
                    end else if (cnt[i] == PW'(1)) begin
                        if (cfg[i].mode == PERIODIC) begin
                            cnt[i] <= cfg[i].period[PW-1:0];
                        end else begin
                            cfg[i].en <= 1'b0;
                            cnt[i]    <= '0;
                        end
                    end
                end
            end
        end
    end

    rr_arb4 u_arb (
        .req    (pending_nxt),
        .ptr    (ptr_nxt),
        .gnt_id (gnt_id),
        .any    (gnt_any)
    );

    // evt_ch is frozen while an offered event waits, even if new requests arrive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending       <= '0;
            ovf           <= '0;
            ch_tick       <= '0;
            ptr           <= '0;
            bus.evt_valid <= 1'b0;
            bus.evt_ch    <= '0;
        end else begin
            pending       <= pending_nxt;
            ovf           <= (ovf & ~{NCH{ovf_clr}}) | ovf_set;
            ch_tick       <= expire;
            ptr           <= ptr_nxt;
            bus.evt_valid <= gnt_any;
            if (!(bus.evt_valid && !bus.evt_ready)) begin
                bus.evt_ch <= gnt_id;
            end
        end
    end

endmodule

// File: tb/tb_tick_sched.sv
// Directed bench for tick_sched with PRESCALE=4: expected events are queued as the
// channel model predicts expiries and popped when the event handshake fires.
module tb_tick_sched;

    localparam int PRESCALE = 4;
    localparam int PW       = 16;

    logic       clk;
    logic       rst_n;
    logic       base_tick;
    logic [3:0] ch_tick;
    logic [3:0] ovf;
    logic       ovf_clr;

    int checks   = 0;
    int failures = 0;
    logic [1:0] exp_q[$];

    tick_sched_if #(.PW(PW)) bus ();

    tick_sched #(.PRESCALE(PRESCALE), .PW(PW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .base_tick (base_tick),
        .ch_tick   (ch_tick),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int ch, input int period, input bit mode, input bit en);
        bit rdy;
        int cyc = 0;
        bus.cfg_valid  = 1'b1;
        bus.cfg_ch     = 2'(ch);
        bus.cfg_period = 16'(period);
        bus.cfg_mode   = mode;
        bus.cfg_en     = en;
        do begin
            rdy = bus.cfg_ready;
            tick();
            cyc++;
        end while (!rdy && cyc < 10);
        bus.cfg_valid = 1'b0;
        chk("cfg_accept", 32'(rdy), 1);
    endtask

    task automatic wait_base();
        int cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!base_tick && cyc < 16);
        chk("base_tick_seen", 32'(base_tick), 1);
    endtask

    task automatic release_check(input int ncyc);
        for (int k = 1; k <= ncyc; k++) begin
            tick();
            chk("base_tick_phase", 32'(base_tick), 32'((k % PRESCALE) == PRESCALE - 1));
            chk("idle_ch_tick", 32'(ch_tick), 0);
            chk("idle_evt_valid", 32'(bus.evt_valid), 0);
        end
    endtask

    // Channel model: counts base ticks since the config was accepted and predicts
    // the cycle after the expiring base tick.
    task automatic run_ch(input int ch, input int period, input bit oneshot,
                          input int nexp, input int tail);
        int n = 0, seen = 0, extra = 0, cyc = 0, obs_cnt = 0;
        bit prev_bt;
        logic [3:0] e;
        prev_bt = base_tick;
        while ((seen < nexp || extra < tail) && cyc < 400) begin
            tick();
            cyc++;
            if (prev_bt) n++;
            e = '0;
            if (prev_bt && (oneshot ? (n == period) : (n % period == 0))) begin
                e = 4'(1) << ch;
                seen++;
                exp_q.push_back(2'(ch));
            end else if (seen >= nexp) begin
                extra++;
            end
            chk("ch_tick", 32'(ch_tick), 32'(e));
            obs_cnt += int'(ch_tick[ch]);
            prev_bt = base_tick;
        end
        chk("ch_tick_count", 32'(obs_cnt), 32'(nexp));
    endtask

    // scoreboard
    always @(negedge clk) begin
        if (rst_n && bus.evt_valid && bus.evt_ready) begin
            chk("evt_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) chk("evt_ch", 32'(bus.evt_ch), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        rst_n          = 1'b0;
        ovf_clr        = 1'b0;
        bus.cfg_valid  = 1'b0;
        bus.cfg_ch     = '0;
        bus.cfg_period = '0;
        bus.cfg_mode   = 1'b0;
        bus.cfg_en     = 1'b0;
        bus.evt_ready  = 1'b0;

        // Reset values and base tick cadence after release
        tick();
        tick();
        chk("rst_base_tick", 32'(base_tick), 0);
        chk("rst_ch_tick", 32'(ch_tick), 0);
        chk("rst_evt_valid", 32'(bus.evt_valid), 0);
        chk("rst_evt_ch", 32'(bus.evt_ch), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_cfg_ready", 32'(bus.cfg_ready), 1);
        rst_n = 1'b1;
        release_check(12);

        // Periodic channel 0, period 3, events drained immediately
        bus.evt_ready = 1'b1;
        cfg_write(0, 3, 1'b0, 1'b1);
        run_ch(0, 3, 1'b0, 3, 2);
        cfg_write(0, 3, 1'b0, 1'b0);
        chk("periodic_ovf", 32'(ovf), 0);
        chk("periodic_queue", 32'(exp_q.size()), 0);

        // One-shot channel 1, period 2
        cfg_write(1, 2, 1'b1, 1'b1);
        run_ch(1, 2, 1'b1, 1, 40);
        chk("oneshot_queue", 32'(exp_q.size()), 0);

        // Overrun on channels 0 and 2 while events are back-pressured
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.evt_ready = 1'b0;
        cfg_write(0, 1, 1'b0, 1'b1);
        cfg_write(2, 1, 1'b0, 1'b1);
        wait_base();
        wait_base();
        wait_base();
        tick();
        cfg_write(0, 1, 1'b0, 1'b0);
        cfg_write(2, 1, 1'b0, 1'b0);
        chk("ovr_ovf", 32'(ovf), 32'h5);
        chk("ovr_evt_valid", 32'(bus.evt_valid), 1);
        chk("ovr_evt_ch_held", 32'(bus.evt_ch), 0);
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd2);
        bus.evt_ready = 1'b1;
        repeat (4) tick();
        chk("ovr_drained_valid", 32'(bus.evt_valid), 0);
        chk("ovr_queue", 32'(exp_q.size()), 0);
        chk("ovr_ovf_sticky", 32'(ovf), 32'h5);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(ovf), 0);

        // Config offered in a base-tick cycle waits one cycle, then loads the counter
        wait_base();
        bus.cfg_valid  = 1'b1;
        bus.cfg_ch     = 2'd3;
        bus.cfg_period = 16'd5;
        bus.cfg_mode   = 1'b0;
        bus.cfg_en     = 1'b1;
        chk("cfg_ready_in_base", 32'(bus.cfg_ready), 0);
        tick();
        chk("cfg_ready_after_base", 32'(bus.cfg_ready), 1);
        tick();
        bus.cfg_valid = 1'b0;
        run_ch(3, 5, 1'b0, 1, 2);
        cfg_write(3, 5, 1'b0, 1'b0);
        chk("late_cfg_queue", 32'(exp_q.size()), 0);

        // Asynchronous reset mid-count with two events pending
        bus.evt_ready = 1'b0;
        cfg_write(0, 1, 1'b0, 1'b1);
        cfg_write(1, 1, 1'b0, 1'b1);
        wait_base();
        tick();
        chk("pre_rst_evt_valid", 32'(bus.evt_valid), 1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_base_tick", 32'(base_tick), 0);
        chk("async_ch_tick", 32'(ch_tick), 0);
        chk("async_evt_valid", 32'(bus.evt_valid), 0);
        chk("async_evt_ch", 32'(bus.evt_ch), 0);
        chk("async_ovf", 32'(ovf), 0);
        chk("async_cfg_ready", 32'(bus.cfg_ready), 1);
        tick();
        rst_n = 1'b1;
        release_check(16);
        chk("post_rst_ovf", 32'(ovf), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
